// File: rtl/pc_event_tx_queue.sv
// rtl/pc_event_tx_queue.sv - prioritised game-event byte queue feeding uart_tx
module pc_event_tx_queue #(
   parameter int         NUM_MOLES  = 5,
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] HIT_CODE   = 8'h48,
   parameter logic [7:0] OVER_CODE  = 8'h52
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              game_active,
   input  logic                              game_finish,
   input  logic                              hit_pulse,
   input  logic [NUM_MOLES-1:0]              mole_onehot,
   input  logic                              tx_busy,
   output logic                              tx_start,
   output logic [7:0]                        tx_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   typedef enum logic [1:0] {IDLE, START, ARM, WAIT} state_t;

   state_t               state_q;
   logic                 tx_start_q;
   logic [7:0]           tx_data_q;
   logic                 finish_q;
   logic                 pend_over_q, pend_hit_q, pend_pos_q;
   logic [3:0]           pos_idx_q;
   logic [NUM_MOLES-1:0] last_pos_q;
   logic                 overflow_q;
   logic [7:0]           mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q;

   logic                 mole_valid, over_ev, pos_ev;
   logic [3:0]           mole_idx;
   logic                 full, empty, wr_en, rd_en;
   logic                 clr_over, clr_hit, clr_pos;
   logic [7:0]           wr_data;

   always_comb begin
      mole_idx = '0;
      for (int i = 0; i < NUM_MOLES; i++)
         if (mole_onehot[i]) mole_idx = 4'(i);
   end

   assign mole_valid = (mole_onehot != '0) &&
                       ((mole_onehot & (mole_onehot - NUM_MOLES'(1))) == '0);
   assign over_ev    = game_finish && !finish_q;
   assign pos_ev     = game_active && mole_valid && (mole_onehot != last_pos_q);

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign wr_en    = !full && (pend_over_q || pend_hit_q || pend_pos_q);
   assign clr_over = wr_en && pend_over_q;
   assign clr_hit  = wr_en && !pend_over_q && pend_hit_q;
   assign clr_pos  = wr_en && !pend_over_q && !pend_hit_q;
   assign wr_data  = pend_over_q ? OVER_CODE :
                     pend_hit_q  ? HIT_CODE  : (8'h30 + {4'b0000, pos_idx_q});
   assign rd_en    = (state_q == IDLE) && !empty && !tx_busy;

   // A new event arriving in the cycle its flag is written keeps the flag set.
   always_ff @(posedge clock) begin
      if (reset) begin
         finish_q    <= 1'b0;
         pend_over_q <= 1'b0;
         pend_hit_q  <= 1'b0;
         pend_pos_q  <= 1'b0;
         pos_idx_q   <= '0;
         last_pos_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         finish_q    <= game_finish;
         pend_over_q <= over_ev || (pend_over_q && !clr_over);
         pend_hit_q  <= hit_pulse || (pend_hit_q && !clr_hit);
         if (hit_pulse && pend_hit_q && !clr_hit)
            overflow_q <= 1'b1;
         if (!game_active) begin
            last_pos_q <= '0;
            pend_pos_q <= 1'b0;
         end else if (pos_ev) begin
            pend_pos_q <= 1'b1;
            pos_idx_q  <= mole_idx;
            last_pos_q <= mole_onehot;
         end else if (clr_pos) begin
            pend_pos_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               tx_start_q <= 1'b0;
               if (rd_en) begin
                  tx_start_q <= 1'b1;
                  tx_data_q  <= mem_q[rd_ptr_q];
                  state_q    <= START;
               end
            end
            START: begin
               tx_start_q <= 1'b0;
               state_q    <= ARM;
            end
            ARM: state_q <= WAIT;
            WAIT: if (!tx_busy) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_pc_event_tx_queue.sv
// tb/tb_pc_event_tx_queue.sv - directed bench for pc_event_tx_queue
module tb_pc_event_tx_queue;
   logic       clock = 1'b0;
   logic       reset, game_active, game_finish, hit_pulse;
   logic [4:0] mole_onehot;
   logic       tx_busy, tx_start, overflow;
   logic [7:0] tx_data;
   logic [3:0] fifo_count;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         busy_cnt = 0;
   bit         busy_force = 1'b0;
   logic [7:0] cap [$];
   logic [7:0] exp_b [$];

   always #5 clock = ~clock;

   pc_event_tx_queue #(.NUM_MOLES(5), .FIFO_DEPTH(8)) dut (
      .clock(clock), .reset(reset), .game_active(game_active),
      .game_finish(game_finish), .hit_pulse(hit_pulse),
      .mole_onehot(mole_onehot), .tx_busy(tx_busy), .tx_start(tx_start),
      .tx_data(tx_data), .fifo_count(fifo_count), .overflow(overflow)
   );

   assign tx_busy = busy_force || (busy_cnt != 0);

   // uart_tx stand-in: captures each byte and stays busy for 10 cycles
   always @(negedge clock) begin
      if (tx_start) begin
         cap.push_back(tx_data);
         busy_cnt = 10;
      end else if (busy_cnt > 0) begin
         busy_cnt = busy_cnt - 1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic hit();
      hit_pulse = 1'b1;
      cyc(1);
      hit_pulse = 1'b0;
   endtask

   task automatic wait_cap(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (cap.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; game_active = 1'b0; game_finish = 1'b0; hit_pulse = 1'b0;
      mole_onehot = '0;
      cyc(3);
      n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %0h expected 0", tx_start); end
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %0h expected 00", tx_data); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0h expected 0", overflow); end
      reset = 1'b0;
      cyc(2);
   endtask

   task automatic test_single_pos();
      cap.delete();
      game_active = 1'b1;
      mole_onehot = 5'b00100;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL lat_early_start: got %0h expected 0", tx_start); end
      n_cmp++; if (fifo_count !== 4'd1) begin n_bad++; $display("FAIL lat_count: got %0d expected 1", fifo_count); end
      @(posedge clock);
      @(negedge clock);
      n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL lat_start: got %0h expected 1", tx_start); end
      n_cmp++; if (tx_data !== 8'h32) begin n_bad++; $display("FAIL lat_data: got %0h expected 32", tx_data); end
      cyc(40);
      n_cmp++; if (cap.size() !== 1) begin n_bad++; $display("FAIL pos_no_repeat: got %0d bytes expected 1", cap.size()); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL pos_drained: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      cap.delete();
      mole_onehot = 5'b00001;
      wait_cap(1, ok);
      cyc(20);
      cap.delete();
      busy_force  = 1'b1;
      game_finish = 1'b1;
      hit_pulse   = 1'b1;
      mole_onehot = 5'b01000;
      cyc(1);
      hit_pulse = 1'b0;
      cyc(5);
      n_cmp++; if (fifo_count !== 4'd3) begin n_bad++; $display("FAIL simul_count: got %0d expected 3", fifo_count); end
      busy_force = 1'b0;
      wait_cap(3, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL simul_timeout: got %0d bytes expected 3", cap.size()); end
      cyc(15);
      exp_b = '{8'h52, 8'h48, 8'h33};
      n_cmp++; if (cap.size() !== 3) begin n_bad++; $display("FAIL simul_size: got %0d expected 3", cap.size()); end
      for (int i = 0; i < 3 && i < cap.size(); i++) begin
         n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL simul_byte%0d: got %0h expected %0h", i, cap[i], exp_b[i]); end
      end
      game_finish = 1'b0;
      cyc(2);
   endtask

   task automatic test_full_backpressure();
      bit ok;
      busy_force  = 1'b1;
      game_active = 1'b0;
      mole_onehot = '0;
      cyc(2);
      game_active = 1'b1;
      cyc(2);
      cap.delete();
      exp_b.delete();
      for (int i = 0; i < 4; i++) begin
         mole_onehot = 5'(1 << i);
         cyc(2);
         hit();
         cyc(1);
         exp_b.push_back(8'h30 + 8'(i));
         exp_b.push_back(8'h48);
      end
      mole_onehot = 5'b10000;
      exp_b.push_back(8'h34);
      cyc(3);
      n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d expected 8", fifo_count); end
      cyc(5);
      n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL full_hold: got %0d expected 8", fifo_count); end
      busy_force = 1'b0;
      wait_cap(9, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_timeout: got %0d bytes expected 9", cap.size()); end
      cyc(15);
      n_cmp++; if (cap.size() !== 9) begin n_bad++; $display("FAIL full_size: got %0d expected 9", cap.size()); end
      for (int i = 0; i < 9 && i < cap.size(); i++) begin
         n_cmp++; if (cap[i] !== exp_b[i]) begin n_bad++; $display("FAIL full_byte%0d: got %0h expected %0h", i, cap[i], exp_b[i]); end
      end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_overflow: got %0h expected 0", overflow); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL full_drained: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_overflow();
      bit ok;
      cap.delete();
      busy_force = 1'b1;
      for (int i = 0; i < 8; i++) begin
         hit();
         cyc(1);
      end
      cyc(2);
      n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL ovf_full: got %0d expected 8", fifo_count); end
      hit();
      cyc(2);
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_first_held: got %0h expected 0", overflow); end
      hit();
      cyc(2);
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0h expected 1", overflow); end
      busy_force = 1'b0;
      wait_cap(9, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_timeout: got %0d bytes expected 9", cap.size()); end
      cyc(30);
      n_cmp++; if (cap.size() !== 9) begin n_bad++; $display("FAIL ovf_size: got %0d expected 9", cap.size()); end
      for (int i = 0; i < cap.size(); i++) begin
         n_cmp++; if (cap[i] !== 8'h48) begin n_bad++; $display("FAIL ovf_byte%0d: got %0h expected 48", i, cap[i]); end
      end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0h expected 1", overflow); end
      game_active = 1'b0;
      mole_onehot = '0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_reset_clear: got %0h expected 0", overflow); end
      reset = 1'b0;
      cyc(2);
   endtask

   task automatic test_invalid_and_resend();
      bit ok;
      cap.delete();
      game_active = 1'b1;
      mole_onehot = 5'b00110;
      cyc(5);
      mole_onehot = 5'b00000;
      cyc(30);
      n_cmp++; if (cap.size() !== 0) begin n_bad++; $display("FAIL invalid_no_byte: got %0d bytes expected 0", cap.size()); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL invalid_count: got %0d expected 0", fifo_count); end
      mole_onehot = 5'b00010;
      wait_cap(1, ok);
      cyc(15);
      game_active = 1'b0;
      cyc(2);
      game_active = 1'b1;
      wait_cap(2, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL resend_timeout: got %0d bytes expected 2", cap.size()); end
      cyc(15);
      n_cmp++; if (cap.size() !== 2) begin n_bad++; $display("FAIL resend_size: got %0d expected 2", cap.size()); end
      for (int i = 0; i < 2 && i < cap.size(); i++) begin
         n_cmp++; if (cap[i] !== 8'h31) begin n_bad++; $display("FAIL resend_byte%0d: got %0h expected 31", i, cap[i]); end
      end
   endtask

   task automatic test_reset_in_wait();
      bit ok;
      cap.delete();
      mole_onehot = 5'b00001;
      wait_cap(1, ok);
      busy_force = 1'b1;
      cyc(3);
      for (int i = 0; i < 3; i++) begin
         hit();
         cyc(1);
      end
      cyc(2);
      n_cmp++; if (fifo_count !== 4'd3) begin n_bad++; $display("FAIL rstwait_queued: got %0d expected 3", fifo_count); end
      reset = 1'b1;
      game_active = 1'b0;
      @(posedge clock);
      @(negedge clock);
      n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL rstwait_start: got %0h expected 0", tx_start); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL rstwait_count: got %0d expected 0", fifo_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rstwait_overflow: got %0h expected 0", overflow); end
      reset = 1'b0;
      busy_force = 1'b0;
      cyc(30);
      n_cmp++; if (cap.size() !== 1) begin n_bad++; $display("FAIL rstwait_no_tx: got %0d bytes expected 1", cap.size()); end
   endtask

   initial begin
      test_reset();
      test_single_pos();
      test_simultaneous();
      test_full_backpressure();
      test_overflow();
      test_invalid_and_resend();
      test_reset_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
